// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard unit.
package hazard_pkg;

  localparam int unsigned HAZ_REG_ADDR_W = 5;
  localparam int unsigned X0_IDX         = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MC_WAIT  = 2'd2
  } haz_state_e;

endpackage

// File: rtl/hazard_lu_cmp.sv
// Combinational load-use comparator: EX load destination vs. ID source operands.
module hazard_lu_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = HAZ_REG_ADDR_W
) (
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  output logic                  lu_hit_c
);

  logic rs1_match;
  logic rs2_match;
  logic rd_live;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign rd_live   = (rd != REG_ADDR_W'(X0_IDX));
  assign rs1_match = use_rs1 && (rd == rs1);
  assign rs2_match = use_rs2 && (rd == rs2);
  assign lu_hit_c  = mem_read && rd_live && (rs1_match || rs2_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard unit: load-use stalls, multi-cycle EX hold, branch flush.
// Optional perf counters (stall_cnt, flush_cnt) enabled by HAZ_PERF_CNT_EN.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W     = HAZ_REG_ADDR_W,
  parameter int unsigned LOAD_USE_STALL = 1
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int unsigned PERF_W         = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [REG_ADDR_W-1:0] if_id_rs1,
  input  logic [REG_ADDR_W-1:0] if_id_rs2,
  input  logic                  if_id_use_rs1,
  input  logic                  if_id_use_rs2,
  input  logic                  branch_taken,
  input  logic                  mc_start,
  input  logic                  mc_done,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  id_ex_write,
  output logic                  if_id_flush,
  output logic                  id_ex_flush
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     stall_cnt,
  output logic [PERF_W-1:0]     flush_cnt
`endif
);

  localparam int unsigned LU_CNT_W = $clog2(LOAD_USE_STALL + 1);

  haz_state_e          state;
  haz_state_e          state_nxt;
  logic [LU_CNT_W-1:0] lu_cnt;
  logic [LU_CNT_W-1:0] lu_cnt_nxt;
  logic                lu_hit;

  hazard_lu_cmp #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lu_cmp (
    .mem_read (id_ex_mem_read),
    .rd       (id_ex_rd),
    .rs1      (if_id_rs1),
    .rs2      (if_id_rs2),
    .use_rs1  (if_id_use_rs1),
    .use_rs2  (if_id_use_rs2),
    .lu_hit_c (lu_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      lu_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  // Next state and pipeline control; reset overrides everything with a safe bubble
  always_comb begin
    state_nxt   = state;
    lu_cnt_nxt  = lu_cnt;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    id_ex_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    unique case (state)
      RUN: begin
        // mc_start with mc_done in the same cycle is a zero-wait op
        if (mc_start && !mc_done) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
          state_nxt   = MC_WAIT;
        end else if (branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (lu_hit) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
          if (LOAD_USE_STALL > 1) begin
            lu_cnt_nxt = LU_CNT_W'(LOAD_USE_STALL - 1);
            state_nxt  = LU_STALL;
          end
        end
      end
      LU_STALL: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
        lu_cnt_nxt  = lu_cnt - LU_CNT_W'(1);
        if (lu_cnt == LU_CNT_W'(1)) begin
          state_nxt = RUN;
        end
      end
      MC_WAIT: begin
        if (mc_done) begin
          state_nxt = RUN;
        end else begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_write = 1'b0;
        end
      end
      default: begin
        state_nxt  = RUN;
        lu_cnt_nxt = '0;
      end
    endcase
    if (!rst_n) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  // Saturating counters; if_id_flush outside reset only ever comes from a taken branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + PERF_W'(1);
      end
      if (if_id_flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + PERF_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: two instances (1 and 3 load-use bubbles) against a
// bubble/busy-count reference model; counter checks only when HAZ_PERF_CNT_EN is set.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       rst_n;
  logic       mr;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       u1;
  logic       u2;
  logic       br;
  logic       ms;
  logic       md;

  logic pw0, iw0, ew0, fi0, fx0;
  logic pw1, iw1, ew1, fi1, fx1;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] sc0, fc0;
  logic [3:0]  sc1, fc1;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: remaining stall bubbles, multi-cycle busy flag, counters
  int     lus  [2];
  int     bub  [2];
  bit     busy [2];
  longint scnt [2];
  longint fcnt [2];
  longint smax [2];

  hazard_stall_ctrl #(
    .REG_ADDR_W     (5),
    .LOAD_USE_STALL (1)
`ifdef HAZ_PERF_CNT_EN
    , .PERF_W       (32)
`endif
  ) u_dut_lus1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_ex_mem_read (mr),
    .id_ex_rd       (rd),
    .if_id_rs1      (rs1),
    .if_id_rs2      (rs2),
    .if_id_use_rs1  (u1),
    .if_id_use_rs2  (u2),
    .branch_taken   (br),
    .mc_start       (ms),
    .mc_done        (md),
    .pc_write       (pw0),
    .if_id_write    (iw0),
    .id_ex_write    (ew0),
    .if_id_flush    (fi0),
    .id_ex_flush    (fx0)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt    (sc0)
    , .flush_cnt    (fc0)
`endif
  );

  hazard_stall_ctrl #(
    .REG_ADDR_W     (5),
    .LOAD_USE_STALL (3)
`ifdef HAZ_PERF_CNT_EN
    , .PERF_W       (4)
`endif
  ) u_dut_lus3 (
    .clk            (clk),
    .rst_n          (rst_n),
    .id_ex_mem_read (mr),
    .id_ex_rd       (rd),
    .if_id_rs1      (rs1),
    .if_id_rs2      (rs2),
    .if_id_use_rs1  (u1),
    .if_id_use_rs2  (u2),
    .branch_taken   (br),
    .mc_start       (ms),
    .mc_done        (md),
    .pc_write       (pw1),
    .if_id_write    (iw1),
    .id_ex_write    (ew1),
    .if_id_flush    (fi1),
    .id_ex_flush    (fx1)
`ifdef HAZ_PERF_CNT_EN
    , .stall_cnt    (sc1)
    , .flush_cnt    (fc1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One pipeline cycle: drive at negedge, compare before the next posedge, advance model
  task automatic step(input logic r, input logic m, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic a1, input logic a2, input logic b,
                      input logic st, input logic dn);
    logic [4:0] got [2];
    bit hit;
    @(negedge clk);
    rst_n = r; mr = m; rd = d; rs1 = s1; rs2 = s2; u1 = a1; u2 = a2;
    br = b; ms = st; md = dn;
    #2;
    got[0] = {pw0, iw0, ew0, fi0, fx0};
    got[1] = {pw1, iw1, ew1, fi1, fx1};
    hit = m && (d != 5'd0) && ((a1 && d == s1) || (a2 && d == s2));
    for (int k = 0; k < 2; k++) begin
      logic [4:0] e;
      bit is_flush;
      int nbub;
      bit nbusy;
      // bit order: pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush
      e = 5'b11100; is_flush = 0; nbub = bub[k]; nbusy = busy[k];
      if (!r) begin
        e = 5'b00011;
      end else if (bub[k] > 0) begin
        e = 5'b00101; nbub = bub[k] - 1;
      end else if (busy[k]) begin
        if (dn) nbusy = 0;
        else e = 5'b00000;
      end else if (st && !dn) begin
        e = 5'b00000; nbusy = 1;
      end else if (b) begin
        e = 5'b11111; is_flush = 1;
      end else if (hit) begin
        e = 5'b00101; nbub = lus[k] - 1;
      end
      check(k == 0 ? "outs_lus1" : "outs_lus3", 32'(got[k]), 32'(e));
`ifdef HAZ_PERF_CNT_EN
      check(k == 0 ? "stall_cnt_lus1" : "stall_cnt_lus3",
            k == 0 ? sc0 : 32'(sc1), 32'(scnt[k]));
      check(k == 0 ? "flush_cnt_lus1" : "flush_cnt_lus3",
            k == 0 ? fc0 : 32'(fc1), 32'(fcnt[k]));
`endif
      if (!r) begin
        bub[k] = 0; busy[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end else begin
        bub[k] = nbub; busy[k] = nbusy;
        if (!e[4] && scnt[k] < smax[k]) scnt[k]++;
        if (is_flush && fcnt[k] < smax[k]) fcnt[k]++;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clk = 0; rst_n = 0; mr = 0; rd = 0; rs1 = 0; rs2 = 0;
    u1 = 0; u2 = 0; br = 0; ms = 0; md = 0;
    lus[0] = 1; lus[1] = 3;
    smax[0] = 64'hffff_ffff; smax[1] = 15;
    for (int k = 0; k < 2; k++) begin
      bub[k] = 0; busy[k] = 0; scnt[k] = 0; fcnt[k] = 0;
    end

    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    idle(1);
    // lw x5 then add using rs1=x5
    step(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0);
    idle(4);
    // dependency on rs2 only
    step(1, 1, 5'd5, 5'd3, 5'd5, 1, 1, 0, 0, 0);
    idle(4);
    // load to x0 never stalls
    step(1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
    // rs2 matches but is not read
    step(1, 1, 5'd5, 5'd3, 5'd5, 1, 0, 0, 0, 0);
    // branch wins over load-use
    step(1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0, 0);
    idle(1);
    // multi-cycle op: start, three waits, done on the fourth cycle
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    idle(3);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    idle(1);
    // zero-wait multi-cycle op
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
    // branch ignored while waiting
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0);
    step(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1);
    idle(1);
    // reset arriving mid-stall abandons it
    step(1, 1, 5'd7, 5'd7, 5'd7, 1, 1, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    step(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      logic r, m, a1, a2, b, st, dn;
      logic [4:0] d, s1, s2;
      r  = ($urandom % 64) != 0;
      m  = 1'($urandom % 2);
      d  = 5'($urandom % 4);
      s1 = 5'($urandom % 4);
      s2 = 5'($urandom % 4);
      a1 = 1'($urandom % 2);
      a2 = 1'($urandom % 2);
      b  = ($urandom % 6) == 0;
      st = ($urandom % 8) == 0;
      dn = ($urandom % 4) == 0;
      if (bub[0] > 0 || bub[1] > 0 || busy[0]) st = 0;
      if ((st && dn) || (dn && busy[0])) begin
        m = 0; b = 0;
      end
      step(r, m, d, s1, s2, a1, a2, b, st, dn);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
